// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory.
// LFSR constants are only used when APB_SLAVE_RANDOM_WAIT_EN is defined.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } apb_state_e;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_BASE = 4;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Feedback taps x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7, 5, 4, 3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic idx_in_range(input logic [7:0] idx, input int depth);
      return (int'({24'h000000, idx}) < depth);
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W register-file storage with async clear, one write port and
// one registered read port that loads zero when the read is not legal.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              rd_ok,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Next storage contents and read-port value
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end else begin
         mem_d = mem_q;
      end
      if (re) begin
         rdata_d = rd_ok ? mem_q[raddr] : {DATA_W{1'b0}};
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Storage and read register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with byte-wide storage, programmable wait states and PSLVERR
// on out-of-range index. Define APB_SLAVE_RANDOM_WAIT_EN to add LFSR-based extra waits.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
   localparam int CNT_W = CNT_W_BASE + 1;
`else
   localparam int CNT_W = CNT_W_BASE;
`endif

   apb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        idx_q, idx_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic              access_s;
   logic              enter_s;
   logic              we_s;
   logic [CNT_W-1:0]  wait_s;
   logic              unused_s;

   // PADDR[8] is decoded upstream by the bridge
   assign unused_s = ^PADDR[ADDR_W-1:8];
   assign access_s = PSEL & PENABLE;

`ifdef APB_SLAVE_RANDOM_WAIT_EN
   logic [7:0] lfsr_q, lfsr_d;
   assign wait_s = CNT_W'(WAIT_CYCLES) + {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
   assign wait_s = CNT_W'(WAIT_CYCLES);
`endif

   // Transfer FSM next-state, latching and response computation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      enter_s   = 1'b0;
      we_s      = 1'b0;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
      lfsr_d    = lfsr_q;
`endif
      case (state_q)
         IDLE: begin
            if (access_s) begin
               idx_d   = PADDR[7:0];
               write_d = PWRITE;
               wdata_d = PWDATA;
               if (wait_s == {CNT_W{1'b0}}) begin
                  state_d = READY;
                  enter_s = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = wait_s - CNT_W'(1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (!access_s) begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = READY;
               enter_s = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         READY: begin
            state_d = IDLE;
            we_s    = access_s & write_q & idx_in_range(idx_q, DEPTH);
`ifdef APB_SLAVE_RANDOM_WAIT_EN
            lfsr_d  = lfsr_next(lfsr_q);
`endif
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      if (enter_s) begin
         pready_d  = 1'b1;
         pslverr_d = ~idx_in_range(idx_d, DEPTH);
      end else begin
         pready_d  = 1'b0;
         pslverr_d = 1'b0;
      end
   end

   // FSM state, latched transfer and registered response
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         idx_q     <= 8'h00;
         write_q   <= 1'b0;
         wdata_q   <= {DATA_W{1'b0}};
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
         lfsr_q    <= LFSR_SEED;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   apb_slave_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (we_s),
      .waddr (idx_q[IDX_W-1:0]),
      .wdata (wdata_q),
      .re    (enter_s),
      .rd_ok (~write_d & idx_in_range(idx_d, DEPTH)),
      .raddr (idx_d[IDX_W-1:0]),
      .rdata (PRDATA)
   );

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with WAIT_CYCLES 0, 1 and 3
// share one APB bus, each with its own PSEL.
module tb_apb_slave_mem;

   typedef struct {
      int         k;
      logic       wr;
      logic [8:0] addr;
      logic [7:0] wd;
      logic [7:0] rd;
      logic       err;
      int         lat;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] psel_v;
   logic       penable;
   logic       pwrite;
   logic [8:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata_v [3];
   logic [2:0] pready_v;
   logic [2:0] pslverr_v;

   int total = 0;
   int bad   = 0;

   vec_t vecs [16];

`ifdef APB_SLAVE_RANDOM_WAIT_EN
   logic [7:0] mlfsr [3];
   function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction
`endif

   apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[0]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_v[0]),
      .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]));
   apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(1)) u_w1 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[1]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_v[1]),
      .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]));
   apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[2]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_v[2]),
      .PREADY(pready_v[2]), .PSLVERR(pslverr_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // One full transfer; returns response sampled at negedge when PREADY is seen
   task automatic xfer(input int k, input logic wr, input logic [8:0] addr,
                       input logic [7:0] wd, input bit mut,
                       output logic [7:0] rd, output logic err,
                       output int lat, output bit bad_err);
      int cyc;
      bit done;
      bad_err = 1'b0; rd = 8'h00; err = 1'b0; lat = 0;
      @(posedge clk); #1;
      psel_v = 3'b000; psel_v[k] = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      cyc = 1; done = 1'b0;
      while (!done && cyc <= 40) begin
         @(negedge clk);
         if (pslverr_v[k] && !pready_v[k]) bad_err = 1'b1;
         if (pready_v[k]) begin
            done = 1'b1; lat = cyc; rd = prdata_v[k]; err = pslverr_v[k];
         end else begin
            @(posedge clk); #1;
            cyc++;
            if (mut) begin
               paddr = addr ^ 9'h001; pwdata = ~wd;
            end
         end
      end
      @(posedge clk); #1;
      psel_v = 3'b000; penable = 1'b0;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
      if (done) mlfsr[k] = ref_lfsr(mlfsr[k]);
`endif
   endtask

   task automatic run(input string nm, input vec_t v, input bit mut);
      logic [7:0] rd;
      logic       err;
      int         lat;
      int         elat;
      bit         be;
      elat = v.lat;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
      elat = elat + int'(mlfsr[v.k][1:0]);
`endif
      xfer(v.k, v.wr, v.addr, v.wd, mut, rd, err, lat, be);
      check({nm, ".rdata"}, int'(rd), int'(v.rd));
      check({nm, ".slverr"}, int'(err), int'(v.err));
      check({nm, ".latency"}, lat, elat);
      check({nm, ".err_wo_ready"}, int'(be), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
`ifdef APB_SLAVE_RANDOM_WAIT_EN
      for (int i = 0; i < 3; i++) mlfsr[i] = 8'hA5;
`endif
   endtask

   initial begin
      bit seen;
      psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 9'h000; pwdata = 8'h00;
      //          k  wr    addr    wd     rd     err   lat
      vecs[0]  = '{1, 1'b0, 9'h005, 8'h00, 8'h00, 1'b0, 3};
      vecs[1]  = '{1, 1'b1, 9'h010, 8'hA5, 8'h00, 1'b0, 3};
      vecs[2]  = '{1, 1'b0, 9'h010, 8'h00, 8'hA5, 1'b0, 3};
      vecs[3]  = '{1, 1'b0, 9'h110, 8'h00, 8'hA5, 1'b0, 3};
      vecs[4]  = '{1, 1'b1, 9'h050, 8'h3C, 8'h00, 1'b1, 3};
      vecs[5]  = '{1, 1'b0, 9'h010, 8'h00, 8'hA5, 1'b0, 3};
      vecs[6]  = '{1, 1'b0, 9'h050, 8'h00, 8'h00, 1'b1, 3};
      vecs[7]  = '{1, 1'b1, 9'h03F, 8'h5A, 8'h00, 1'b0, 3};
      vecs[8]  = '{1, 1'b0, 9'h03F, 8'h00, 8'h5A, 1'b0, 3};
      vecs[9]  = '{1, 1'b0, 9'h040, 8'h00, 8'h00, 1'b1, 3};
      vecs[10] = '{1, 1'b0, 9'h1FF, 8'h00, 8'h00, 1'b1, 3};
      vecs[11] = '{0, 1'b1, 9'h001, 8'h77, 8'h00, 1'b0, 2};
      vecs[12] = '{0, 1'b0, 9'h001, 8'h00, 8'h77, 1'b0, 2};
      vecs[13] = '{0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b0, 2};
      vecs[14] = '{2, 1'b1, 9'h000, 8'h11, 8'h00, 1'b0, 5};
      vecs[15] = '{2, 1'b0, 9'h000, 8'h00, 8'h11, 1'b0, 5};

      do_reset();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset%0d.pready", k), int'(pready_v[k]), 0);
         check($sformatf("reset%0d.pslverr", k), int'(pslverr_v[k]), 0);
         check($sformatf("reset%0d.prdata", k), int'(prdata_v[k]), 0);
      end

      for (int i = 0; i < 16; i++) run($sformatf("v%0d", i), vecs[i], 1'b0);

      // Address/data changes after the first access cycle must be ignored
      run("latch_wr", '{1, 1'b1, 9'h020, 8'h66, 8'h00, 1'b0, 3}, 1'b1);
      run("latch_rd0", '{1, 1'b0, 9'h020, 8'h00, 8'h66, 1'b0, 3}, 1'b0);
      run("latch_rd1", '{1, 1'b0, 9'h021, 8'h00, 8'h00, 1'b0, 3}, 1'b0);

      // Abort: drop PSEL during WAIT of a write of 0x22 to index 0
      @(posedge clk); #1;
      psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 9'h000; pwdata = 8'h22;
      @(posedge clk); #1 penable = 1'b1;
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (pready_v[2]) seen = 1'b1;
         @(posedge clk); #1;
      end
      psel_v = 3'b000; penable = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (pready_v[2]) seen = 1'b1;
      end
      check("abort.no_pready", int'(seen), 0);
      run("abort_rd", '{2, 1'b0, 9'h000, 8'h00, 8'h11, 1'b0, 5}, 1'b0);

      // Reset in the middle of a WAIT phase of a write
      @(posedge clk); #1;
      psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 9'h000; pwdata = 8'h99;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid.pready", int'(pready_v), 0);
      check("rst_mid.pslverr", int'(pslverr_v), 0);
      check("rst_mid.prdata2", int'(prdata_v[2]), 0);
      check("rst_mid.prdata1", int'(prdata_v[1]), 0);
      psel_v = 3'b000; penable = 1'b0;
      do_reset();
      run("rst_rd2", '{2, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0, 5}, 1'b0);
      run("rst_rd1a", '{1, 1'b0, 9'h010, 8'h00, 8'h00, 1'b0, 3}, 1'b0);
      run("rst_rd1b", '{1, 1'b0, 9'h03F, 8'h00, 8'h00, 1'b0, 3}, 1'b0);

`ifdef APB_SLAVE_RANDOM_WAIT_EN
      do_reset();
      for (int i = 0; i < 8; i++)
         run($sformatf("rnd%0d", i), '{1, 1'b0, 9'h005, 8'h00, 8'h00, 1'b0, 3}, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer with byte-wide register-file storage, driven by the two-slave APB bridge.
- One instance hangs off PSEL1 and one off PSEL2. PADDR[8] is decoded by the bridge, so this block uses only the low index bits.
- Inserts programmable wait states via PREADY.
- Flags out-of-range accesses with PSLVERR.

Parameters:
- ADDR_W, 9, PADDR width (matches bridge).
- DATA_W, 8, PWDATA/PRDATA width.
- DEPTH, 64, number of DATA_W-bit storage words; index = PADDR[7:0]; legal index 0..DEPTH-1; DEPTH <= 256.
- WAIT_CYCLES, 1, extra wait states per transfer (0..15).

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select from bridge.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  address; bits [7:0] index storage, bit 8 ignored.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid when PREADY=1 and PWRITE=0.
- PREADY  out  1  transfer-complete strobe (registered).
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (async, PRESETn=0): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, all storage words=0.
- FSM states: IDLE, WAIT, READY. Sampling is on rising PCLK.
- IDLE:
  - PSEL=1 and PENABLE=1 → latch PADDR/PWRITE/PWDATA.
  - If WAIT_CYCLES=0 → go to READY; else → go to WAIT with cnt=WAIT_CYCLES-1.
  - PSEL=1 and PENABLE=0 (setup phase) → stay in IDLE.
- WAIT:
  - cnt=0 → go to READY; else cnt-1.
  - PSEL=0 or PENABLE=0 (abort) → go to IDLE. No storage change; PREADY stays 0.
- Entry to READY (registered, same edge):
  - PREADY=1.
  - PSLVERR = (index >= DEPTH).
  - PRDATA = storage[index] for a legal read, else 0.
- READY, edge with PSEL=1 and PENABLE=1:
  - Completes the transfer.
  - Legal write commits PWDATA to storage[index] at this edge; error writes are discarded.
  - Go to IDLE; PREADY=0, PSLVERR=0. PRDATA holds its value.
- READY, edge with PSEL=0: go to IDLE with no write.
- Latency: access phase lasts exactly WAIT_CYCLES+2 PCLK cycles; PREADY is high in the last cycle only.
- Back-to-back transfers: a new setup phase may follow directly. IDLE re-arms on the next PSEL&PENABLE.
- Address/data are latched at the first access cycle. Later changes during WAIT are ignored.
- Reset asserted mid-transfer: immediate return to reset values. A pending write is lost.
- PSLVERR never asserts without PREADY.

Optional Feature:
- Macro APB_SLAVE_RANDOM_WAIT_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
  - Advances once per completed transfer (READY exit).
  - Effective wait = WAIT_CYCLES + lfsr[1:0]; counter width grows by 1 bit.
- Undefined: wait is fixed at WAIT_CYCLES; no LFSR logic.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, WAIT, READY);
  - ADDR_W/DATA_W defaults;
  - LFSR seed/tap constants;
  - helper function for the in-range check.
- One sub-module, apb_slave_regfile: DEPTH x DATA_W storage with async clear, one registered read port and one write port.
- The FSM and wait counter stay in apb_slave_mem.

Test Plan:
- Reset, then read index 0x05 → PRDATA=0x00, PSLVERR=0; access phase is 3 cycles with WAIT_CYCLES=1.
- Write 0xA5 to PADDR=9'h010, then read 9'h010 → PRDATA=0xA5 with PREADY high in the 3rd access cycle; PADDR=9'h110 on the same instance also returns 0xA5 (bit 8 ignored).
- Write 0x3C to PADDR=9'h050 (index 80 ≥ 64) → PSLVERR=1 with PREADY. A subsequent read of index 0x10 still returns 0xA5, and no storage changes.
- WAIT_CYCLES=3, write 0x11 to 0x00 → PREADY rises exactly 4 cycles after PENABLE; drop PSEL during WAIT on a second write of 0x22 to 0x00 → no PREADY; reading 0x00 returns 0x11.
- Assert PRESETn=0 mid-WAIT of a write → PREADY/PSLVERR/PRDATA go to 0 immediately; storage reads 0 afterwards.
- With APB_SLAVE_RANDOM_WAIT_EN: 8 back-to-back reads → wait counts match the reference LFSR model from seed 8'hA5.
